// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues in-order fetches, tags each response with its PC,
// buffers instructions for decode and discards responses made stale by a redirect.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [DATA_WIDTH-1:0] pc_f,
    output logic [DATA_WIDTH-1:0] pcPlus4_f
);

    localparam int                    CNT_W    = $clog2(DEPTH + 1);
    localparam int                    PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]        LIMIT    = (CNT_W + 1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP      = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH-1:0] FOUR     = DATA_WIDTH'(4);

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      drop_q, drop_d;
    logic [CNT_W-1:0]      buf_count_q, buf_count_d;
    logic [PTR_W-1:0]      tag_wr_q, tag_rd_q, buf_wr_q, buf_rd_q;
    logic [DATA_WIDTH-1:0] tag_mem_q  [DEPTH];
    logic [DATA_WIDTH-1:0] buf_pc_q   [DEPTH];
    logic [DATA_WIDTH-1:0] buf_data_q [DEPTH];
    logic [DATA_WIDTH-1:0] last_pc_q, last_pc4_q;

    logic [CNT_W:0]        in_flight;
    logic                  req_fire, rsp_take, buf_push, buf_pop;
    logic [DATA_WIDTH-1:0] head_pc, head_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Requests are capped so every in-flight response is guaranteed a buffer slot.
    assign in_flight      = {1'b0, outstanding_q} + {1'b0, buf_count_q};
    assign imem_req_valid = !rst && !redirect && (in_flight < LIMIT);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_take       = imem_rsp_valid && (outstanding_q != '0);
    assign buf_push       = rsp_take && (drop_q == '0) && !redirect;
    assign instr_valid    = (buf_count_q != '0);
    assign buf_pop        = instr_valid && !stall && !redirect;

    assign head_pc     = buf_pc_q[buf_rd_q];
    assign head_data   = buf_data_q[buf_rd_q];
    assign instruction = instr_valid ? head_data : NOP;
    assign pc_f        = instr_valid ? head_pc : last_pc_q;
    assign pcPlus4_f   = instr_valid ? head_pc + FOUR : last_pc4_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = {redirect_target[DATA_WIDTH-1:2], 2'b00};
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + FOUR;
        end

        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_take);

        // Everything still in flight after a redirect belongs to the abandoned path.
        drop_d = drop_q;
        if (redirect) begin
            drop_d = outstanding_q - CNT_W'(rsp_take);
        end else if (rsp_take && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
        end

        buf_count_d = buf_count_q + CNT_W'(buf_push) - CNT_W'(buf_pop);
        if (redirect) begin
            buf_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            buf_count_q   <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            buf_wr_q      <= '0;
            buf_rd_q      <= '0;
            last_pc_q     <= '0;
            last_pc4_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            buf_count_q   <= buf_count_d;
            if (req_fire) tag_wr_q <= ptr_inc(tag_wr_q);
            if (rsp_take) tag_rd_q <= ptr_inc(tag_rd_q);
            if (redirect) begin
                buf_wr_q <= '0;
                buf_rd_q <= '0;
            end else begin
                if (buf_push) buf_wr_q <= ptr_inc(buf_wr_q);
                if (buf_pop)  buf_rd_q <= ptr_inc(buf_rd_q);
            end
            if (instr_valid) begin
                last_pc_q  <= pc_f;
                last_pc4_q <= pcPlus4_f;
            end
        end
    end

    // Storage carries no reset; occupancy is tracked entirely by the counters above.
    always_ff @(posedge clk) begin
        if (req_fire) tag_mem_q[tag_wr_q] <= fetch_pc_q;
        if (buf_push) begin
            buf_pc_q[buf_wr_q]   <= tag_mem_q[tag_rd_q];
            buf_data_q[buf_wr_q] <= imem_rsp_data;
        end
    end

    rsp_without_request: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (outstanding_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a queue-based reference model.
module tb_fetch_unit;

    localparam int          DW       = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect;
    logic [31:0] redirect_target;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instruction, pc_f, pcPlus4_f;

    fetch_unit #(.DATA_WIDTH(DW), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instruction(instruction),
        .pc_f(pc_f), .pcPlus4_f(pcPlus4_f)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic stale; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ins_t;
    typedef struct { int due; logic [31:0] data; } mem_t;

    infl_t       m_infl[$];
    ins_t        m_buf[$];
    mem_t        mem_q[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] m_pc, m_last_pc, m_last_pc4;
    logic        exp_rv;
    int          cyc, last_due, ready_pct, lat_min, lat_max;
    int          n_vec, n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_infl.delete();
        m_buf.delete();
        mem_q.delete();
        m_pc       = RESET_PC;
        m_last_pc  = '0;
        m_last_pc4 = '0;
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] tgt);
        @(negedge clk);
        stall           = st;
        redirect        = rd;
        redirect_target = tgt;
        imem_req_ready  = (int'($urandom_range(99)) < ready_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic check();
        logic        iv;
        logic [31:0] e_ins, e_pc, e_pc4;
        #1;
        iv     = (m_buf.size() > 0);
        e_ins  = iv ? m_buf[0].data : NOP;
        e_pc   = iv ? m_buf[0].pc : m_last_pc;
        e_pc4  = iv ? m_buf[0].pc + 32'd4 : m_last_pc4;
        exp_rv = !redirect && ((m_infl.size() + m_buf.size()) < DEPTH);
        chk("instr_valid", 32'(instr_valid), 32'(iv));
        chk("instruction", instruction, e_ins);
        chk("pc_f", pc_f, e_pc);
        chk("pcPlus4_f", pcPlus4_f, e_pc4);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        chk("req_addr", imem_req_addr, m_pc);
    endtask

    task automatic advance();
        logic  hs, rsp, pop;
        infl_t f;
        int    lat, due;
        hs  = exp_rv && imem_req_ready;
        rsp = imem_rsp_valid && (m_infl.size() > 0);
        pop = (m_buf.size() > 0) && !stall && !redirect;
        @(posedge clk);
        cyc++;
        if (m_buf.size() > 0) begin
            m_last_pc  = m_buf[0].pc;
            m_last_pc4 = m_buf[0].pc + 32'd4;
        end
        if (pop) begin
            pop_log.push_back(m_buf[0].pc);
            void'(m_buf.pop_front());
        end
        if (rsp) begin
            void'(mem_q.pop_front());
            f = m_infl.pop_front();
            if (!redirect && !f.stale) m_buf.push_back('{pc: f.addr, data: imem_rsp_data});
        end
        if (redirect) begin
            m_buf.delete();
            foreach (m_infl[i]) m_infl[i].stale = 1'b1;
            m_pc = {redirect_target[31:2], 2'b00};
        end else if (hs) begin
            lat = int'($urandom_range(lat_max, lat_min));
            due = cyc + lat - 1;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            m_infl.push_back('{addr: m_pc, stale: 1'b0});
            mem_q.push_back('{due: due, data: $urandom});
            req_log.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
        drive(st, rd, tgt);
        check();
        advance();
    endtask

    initial begin
        int   n, k;
        logic found;
        n_vec = 0; n_err = 0; cyc = 0; last_due = 0;
        ready_pct = 100; lat_min = 1; lat_max = 1;
        stall = 1'b0; redirect = 1'b0; redirect_target = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        rst = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instruction", instruction, NOP);
        chk("rst_pc_f", pc_f, 32'd0);
        chk("rst_pcPlus4_f", pcPlus4_f, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Streaming from a reset PC that wraps through zero
        drive(1'b0, 1'b0, '0);
        check();
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, RESET_PC);
        advance();
        repeat (14) step(1'b0, 1'b0, '0);
        chk("wrap_req0", req_log[0], 32'hFFFF_FFF8);
        chk("wrap_req1", req_log[1], 32'hFFFF_FFFC);
        chk("wrap_req2", req_log[2], 32'h0000_0000);
        chk("stream_pop0", pop_log[0], 32'hFFFF_FFF8);
        chk("stream_pop2", pop_log[2], 32'h0000_0000);
        chk("stream_pop5", pop_log[5], 32'h0000_000C);

        // Backpressure: fill the buffer from PC 8 while stalled
        step(1'b1, 1'b1, 32'h0000_0008);
        repeat (8) step(1'b1, 1'b0, '0);
        repeat (5) begin
            drive(1'b1, 1'b0, '0);
            check();
            chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
            chk("bp_instr_valid", 32'(instr_valid), 32'd1);
            chk("bp_head_pc", pc_f, 32'h0000_0008);
            advance();
        end
        n = pop_log.size();
        repeat (6) step(1'b0, 1'b0, '0);
        chk("bp_pop0", pop_log[n], 32'h0000_0008);
        chk("bp_pop1", pop_log[n + 1], 32'h0000_000C);

        // Redirect with two requests outstanding
        ready_pct = 0;
        repeat (6) step(1'b0, 1'b0, '0);
        ready_pct = 100; lat_min = 4; lat_max = 4;
        repeat (2) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0000_0102);
        lat_min = 1; lat_max = 1;
        found = 1'b0; k = 0;
        while (!found && k < 20) begin
            drive(1'b0, 1'b0, '0);
            check();
            if (instr_valid) begin
                chk("redir_pc_f", pc_f, 32'h0000_0100);
                chk("redir_pcPlus4_f", pcPlus4_f, 32'h0000_0104);
                found = 1'b1;
            end
            advance();
            k++;
        end
        chk("redir_seen", 32'(found), 32'd1);

        // Redirect in the same cycle as a response
        lat_min = 2; lat_max = 2;
        found = 1'b0; k = 0;
        while (!found && k < 40) begin
            drive(1'b0, 1'b0, '0);
            if (imem_rsp_valid && k > 4) begin
                redirect        = 1'b1;
                redirect_target = 32'h0000_0203;
                found           = 1'b1;
            end
            check();
            advance();
            k++;
        end
        chk("rr_seen", 32'(found), 32'd1);
        found = 1'b0; k = 0;
        while (!found && k < 20) begin
            drive(1'b0, 1'b0, '0);
            check();
            if (instr_valid) begin
                chk("rr_pc_f", pc_f, 32'h0000_0200);
                found = 1'b1;
            end
            advance();
            k++;
        end
        chk("rr_next_seen", 32'(found), 32'd1);

        // Random traffic
        ready_pct = 70; lat_min = 1; lat_max = 4;
        repeat (400) step($urandom_range(99) < 30, $urandom_range(99) < 5, $urandom);

        // Asynchronous reset pulse between clock edges, memory quiesced
        ready_pct = 100; lat_min = 1; lat_max = 1;
        repeat (6) step(1'b0, 1'b0, '0);
        #2;
        rst            = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        model_reset();
        #1;
        chk("arst_instr_valid", 32'(instr_valid), 32'd0);
        chk("arst_instruction", instruction, NOP);
        chk("arst_pc_f", pc_f, 32'd0);
        chk("arst_pcPlus4_f", pcPlus4_f, 32'd0);
        #1 rst = 1'b0;
        drive(1'b0, 1'b0, '0);
        check();
        chk("arst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("arst_req_addr", imem_req_addr, RESET_PC);
        advance();
        repeat (10) step(1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of the address, instruction and PC.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 SHALL have parameter DEPTH, default 2, meaning the combined limit on in-flight requests plus buffered instructions.
REQ-004 SHALL have these ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  1  hazard unit hold; the head instruction is not consumed.
- redirect  in  1  branch/jump taken, from execute.
- redirect_target  in  DATA_WIDTH  new PC when redirect=1.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  DATA_WIDTH  fetch address.
- imem_rsp_valid  in  1  response valid; always accepted.
- imem_rsp_data  in  DATA_WIDTH  instruction word; responses return in request order.
- instr_valid  out  1  the head instruction is valid.
- instruction  out  DATA_WIDTH  to the IF/ID register.
- pc_f  out  DATA_WIDTH  PC of the head instruction.
- pcPlus4_f  out  DATA_WIDTH  pc_f+4.

Function
REQ-005 SHALL hold fetch_pc, which drives imem_req_addr; request handshake = imem_req_valid & imem_req_ready.
REQ-006 SHALL assert imem_req_valid only when redirect=0 and (outstanding + buf_count) < DEPTH.
REQ-007 SHALL, on a request handshake, advance fetch_pc by 4 (modulo 2^DATA_WIDTH, 32'hFFFF_FFFC wraps to 0), increment outstanding, and push the fetch address into the in-order tag FIFO.
REQ-008 SHALL, on a response with drop_count=0, pop the tag FIFO, decrement outstanding, and push {tag, imem_rsp_data} into the instruction buffer.
REQ-009 SHALL, on a response with drop_count>0, discard the data, pop the tag FIFO, decrement outstanding and decrement drop_count.
REQ-010 SHALL drive instr_valid=1 iff buf_count>0; instruction, pc_f and pcPlus4_f come combinationally from the buffer head.
REQ-011 SHALL, when instr_valid=0, drive instruction=32'h0000_0013 (NOP), with pc_f and pcPlus4_f equal to their last driven values.
REQ-012 SHALL pop the buffer head when instr_valid=1, stall=0 and redirect=0.
REQ-013 SHALL allow a push and a pop in the same cycle, leaving buf_count unchanged.
REQ-014 SHALL, when redirect=1 in a cycle:
- clear the instruction buffer;
- set fetch_pc to {redirect_target[DATA_WIDTH-1:2], 2'b00};
- set drop_count to the outstanding count after that cycle's response is accounted for;
- issue no request.
REQ-015 SHALL give redirect priority over stall and over any response arriving in the same cycle; that response is discarded.
REQ-016 SHALL leave outstanding unchanged when a handshake and a response occur in the same cycle.
REQ-017 SHALL never let outstanding + buf_count exceed DEPTH.
REQ-018 SHALL give a response at cycle N a first possible appearance on instr_valid in cycle N+1.
REQ-019 SHALL ignore an imem_rsp_valid that arrives with outstanding=0; this is a protocol error and is asserted in simulation.

Reset
REQ-020 SHALL, while rst=1, immediately force:
- fetch_pc=RESET_PC;
- outstanding=0, drop_count=0, buf_count=0;
- instr_valid=0, instruction=32'h0000_0013, pc_f=0, pcPlus4_f=0.
REQ-021 SHALL, when rst is asserted mid-transaction, treat in-flight responses that arrive after rst releases as protocol errors; the environment must quiesce memory first.
REQ-022 SHALL assert imem_req_valid in the first cycle after rst deasserts.

Verification
REQ-023 SHALL cover streaming: 1-cycle memory latency, ready=1, stall=0 -> instructions at PC 0,4,8,12 appear on consecutive cycles with pcPlus4_f=4,8,12,16.
REQ-024 SHALL cover backpressure: stall=1 for 5 cycles with 2 instructions buffered -> imem_req_valid=0, head held at pc_f=8, and no loss after release.
REQ-025 SHALL cover redirect with 2 outstanding: redirect_target=32'h0000_0102 -> both stale responses dropped, and the next instr_valid carries pc_f=32'h0000_0100.
REQ-026 SHALL cover redirect and response in the same cycle: that response is discarded, drop_count equals the remaining outstanding, and no stale PC is ever presented.
REQ-027 SHALL cover wrap: RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-028 SHALL cover async reset mid-stream: rst pulses between clock edges -> outputs immediately read instr_valid=0, instruction=NOP, and the first request after release uses RESET_PC.
